// File: rtl/handshake_sched_pkg.sv
// rtl/handshake_sched_pkg.sv - shared slot state type and default constant table
package handshake_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // req0=EE, req1=11, req2=22, req3=44
    localparam logic [31:0] DEFAULT_CONST_TABLE = 32'h442211EE;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting after the last winner
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    input  logic                 enable,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] cand;
    logic                 found;

    // Walk candidates last+1, last+2, ... with wrap; the first requesting one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, last_grant} + (IDX_WIDTH+1)'(off);
            if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
            end
            cand = sum[IDX_WIDTH-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/handshake_const_scheduler.sv
// rtl/handshake_const_scheduler.sv - round-robin scheduler emitting per-requester constants
module handshake_const_scheduler
    import handshake_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = DEFAULT_CONST_TABLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] outs_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  last_grant_q;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] const_sel;
    logic                  load_en;
    logic                  arb_en;
    logic                  any_grant;

    // The slot can take a new token when empty or when its current one leaves now.
    // Gating with rst keeps ctrl_ready low for the whole reset window.
    assign load_en   = (state_q == ST_EMPTY) || outs_ready;
    assign arb_en    = load_en && rst;
    assign any_grant = |grant;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_arb (
        .req        (ctrl_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Select the constant belonging to the winning requester.
    always_comb begin
        const_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
                const_sel = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next slot state: a grant always fills, a drain without refill empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_grant) state_d = ST_FULL;
            ST_FULL:  if (outs_ready) state_d = any_grant ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Slot occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_EMPTY;
        else      state_q <= state_d;
    end

    // Slot data register; holds its value unless a new token is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_q <= '0;
            idx_q  <= '0;
        end else if (any_grant) begin
            outs_q <= const_sel;
            idx_q  <= grant_idx;
        end
    end

    // Last winner; resets to the top index so req0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           last_grant_q <= IDX_WIDTH'(NUM_REQ-1);
        else if (any_grant) last_grant_q <= grant_idx;
    end

    assign ctrl_ready = grant;
    assign outs       = outs_q;
    assign outs_idx   = idx_q;
    assign outs_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_handshake_const_scheduler.sv
// tb/tb_handshake_const_scheduler.sv - scoreboard bench for handshake_const_scheduler
module tb_handshake_const_scheduler;

    localparam int N = 4;
    localparam logic [7:0] EXP_CONST [4] = '{8'hEE, 8'h11, 8'h22, 8'h44};

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
    } tok_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ctrl_valid;
    logic [3:0] ctrl_ready;
    logic [7:0] outs;
    logic [1:0] outs_idx;
    logic       outs_valid;
    logic       outs_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    handshake_const_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_idx   (outs_idx),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a single-entry slot plus a rotating priority pointer.
    int         m_last = N - 1;
    bit         m_full = 1'b0;
    tok_t       sb[$];
    int         wait_cnt[N];
    int         max_wait = 0;
    int         p_g;
    bit         p_found;
    logic [3:0] p_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_ctrl_ready", 32'(ctrl_ready), 32'h0);
            check("reset_outs_valid", 32'(outs_valid), 32'h0);
            m_last = N - 1;
            m_full = 1'b0;
            sb.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            check("outs_valid_vs_model", 32'(outs_valid), 32'(m_full));
            p_rdy   = 4'b0000;
            p_found = 1'b0;
            p_g     = 0;
            if ((!m_full || outs_ready) && ctrl_valid != 4'b0000) begin
                for (int k = 1; k <= N; k++) begin
                    if (!p_found && ctrl_valid[(m_last + k) % N]) begin
                        p_found = 1'b1;
                        p_g     = (m_last + k) % N;
                    end
                end
                p_rdy[p_g] = 1'b1;
            end
            check("ctrl_ready_vs_model", 32'(ctrl_ready), 32'(p_rdy));
            for (int i = 0; i < N; i++) begin
                if (!ctrl_valid[i]) wait_cnt[i] = 0;
            end
            if (p_found) begin
                sb.push_back('{data: EXP_CONST[p_g], idx: 2'(p_g)});
                m_last = p_g;
                m_full = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (i == p_g) wait_cnt[i] = 0;
                    else if (ctrl_valid[i]) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
            end else if (m_full && outs_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: every presented output token must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && outs_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output_token", 32'(outs), 32'hFFFF_FFFF);
            end else begin
                check("outs_data", 32'(outs), 32'(sb[0].data));
                check("outs_idx", 32'(outs_idx), 32'(sb[0].idx));
                if (outs_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] v, input logic r);
        ctrl_valid = v;
        outs_ready = r;
        #1;
    endtask

    task automatic pulse_reset();
        rst        = 1'b0;
        ctrl_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        ctrl_valid = 4'b1111;
        outs_ready = 1'b1;
        repeat (3) tick();
        check("rst_ready_zero", 32'(ctrl_ready), 32'h0);
        check("rst_outs", 32'(outs), 32'h0);
        check("rst_idx", 32'(outs_idx), 32'h0);
        check("rst_valid", 32'(outs_valid), 32'h0);

        // First token after reset comes from req0 one cycle after the handshake.
        rst = 1'b1;
        set(4'b0001, 1'b1);
        check("first_ready", 32'(ctrl_ready), 32'h1);
        tick();
        check("first_outs", 32'(outs), 32'hEE);
        check("first_idx", 32'(outs_idx), 32'h0);
        check("first_valid", 32'(outs_valid), 32'h1);

        // All requesters active: full rotation at one token per cycle.
        pulse_reset();
        set(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rotate_outs", 32'(outs), 32'(EXP_CONST[k % 4]));
            check("rotate_idx", 32'(outs_idx), 32'(k % 4));
        end

        // Backpressure holds req1's token and blocks grants.
        tick();
        set(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("stall_ready", 32'(ctrl_ready), 32'h0);
            check("stall_outs", 32'(outs), 32'h11);
            tick();
        end
        set(4'b1111, 1'b1);
        check("resume_ready", 32'(ctrl_ready), 32'h4);
        tick();
        check("resume_outs", 32'(outs), 32'h22);

        // Pointer at 3: lone req3 found by wrapping, then req0.
        tick();
        check("to_req3_outs", 32'(outs), 32'h44);
        set(4'b1000, 1'b1);
        check("wrap_ready3", 32'(ctrl_ready), 32'h8);
        tick();
        check("wrap_outs3", 32'(outs), 32'h44);
        check("wrap_idx3", 32'(outs_idx), 32'h3);
        set(4'b0001, 1'b1);
        check("wrap_ready0", 32'(ctrl_ready), 32'h1);
        tick();
        check("wrap_outs0", 32'(outs), 32'hEE);

        // Reset mid-transfer discards the held 0x22 immediately.
        set(4'b0100, 1'b1);
        tick();
        set(4'b0000, 1'b0);
        tick();
        check("pre_reset_outs", 32'(outs), 32'h22);
        check("pre_reset_valid", 32'(outs_valid), 32'h1);
        rst = 1'b0;
        #1;
        check("async_reset_valid", 32'(outs_valid), 32'h0);
        check("async_reset_outs", 32'(outs), 32'h0);
        ctrl_valid = 4'b0101;
        outs_ready = 1'b1;
        #1;
        check("reset_blocks_ready", 32'(ctrl_ready), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        set(4'b0101, 1'b1);
        check("post_reset_ready", 32'(ctrl_ready), 32'h1);
        tick();
        check("post_reset_outs", 32'(outs), 32'hEE);

        // Random traffic checked by the model and scoreboard.
        for (int c = 0; c < 10000; c++) begin
            set(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end

        set(4'b0000, 1'b1);
        tick();
        tick();
        check("drain_scoreboard_empty", 32'(sb.size()), 32'h0);
        check("drain_outs_valid", 32'(outs_valid), 32'h0);
        check("starvation_bound_ok", 32'(max_wait <= N - 1), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
